// File: rtl/vga_rd_fifo_ctrl.sv
// Frame fetcher for the VGA timing stage: pulls SDRAM bursts into a FWFT FIFO
// and restarts the frame address on every vsync rise.
module vga_rd_fifo_ctrl #(
  parameter int FRAME_WORDS = 737280,
  parameter int BURST_LEN   = 256,
  parameter int FIFO_DEPTH  = 1024,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 22
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              vga_vsync,
  input  logic              vga_en,
  output logic [15:0]       img_data,
  output logic              rd_req,
  input  logic              rd_ack,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [15:0]       rd_data,
  output logic              underflow,
  output logic              overflow,
  output logic [2:0]        dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam int BW = $clog2(BURST_LEN);

  localparam logic [LW-1:0]     LVL_FULL   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]     LVL_THR    = LW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [WW-1:0]     WORDS_END  = WW'(FRAME_WORDS);
  localparam logic [WW-1:0]     WORDS_STEP = WW'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BURST_LEN);
  localparam logic [BW-1:0]     BEAT_LAST  = BW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    CHECK = 3'd2,
    REQ   = 3'd3,
    DATA  = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t            state;
  logic [15:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [WW-1:0]     words_req;
  logic [BW-1:0]     beat_cnt;
  logic              flush_owed;
  logic              vsync_q, vsync_rise;
  logic              empty, full, push, pop, beat_last;

  assign dbg_state = state;
  assign empty     = (level == '0);
  assign full      = (level == LVL_FULL);
  assign beat_last = (beat_cnt == BEAT_LAST);
  assign push      = rd_valid && !full && (state != DRAIN) && (state != FLUSH);
  assign pop       = vga_en && !empty && (state != FLUSH);
  assign img_data  = empty ? 16'h0000 : mem[rd_ptr];

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      vsync_q    <= 1'b0;
      vsync_rise <= 1'b0;
    end else begin
      vsync_q    <= vga_vsync;
      vsync_rise <= vga_vsync && !vsync_q;
    end
  end

  always_ff @(posedge sclk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (state == FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // Sticky error flags; a new frame (vsync rise) wins over a same-cycle set.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else if (vsync_rise || state == FLUSH) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (vga_en && empty) underflow <= 1'b1;
      if (rd_valid && full && state != DRAIN) overflow <= 1'b1;
    end
  end

  // rd_req rises on entry to REQ and holds with rd_addr stable until the
  // single-cycle rd_ack; the accepted burst is then always received in full.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state      <= IDLE;
      rd_req     <= 1'b0;
      rd_addr    <= ADDR_BASE;
      words_req  <= '0;
      beat_cnt   <= '0;
      flush_owed <= 1'b0;
    end else begin
      case (state)
        IDLE: if (vsync_rise) state <= FLUSH;
        FLUSH: begin
          rd_req     <= 1'b0;
          rd_addr    <= ADDR_BASE;
          words_req  <= '0;
          flush_owed <= 1'b0;
          state      <= CHECK;
        end
        CHECK: begin
          if (vsync_rise)                  state <= FLUSH;
          else if (words_req == WORDS_END) state <= DONE;
          else if (level <= LVL_THR) begin
            rd_req <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (rd_ack) begin
            rd_req   <= 1'b0;
            beat_cnt <= '0;
            state    <= (vsync_rise || flush_owed) ? DRAIN : DATA;
          end else if (vsync_rise) begin
            flush_owed <= 1'b1;
          end
        end
        DATA: begin
          if (rd_valid) beat_cnt <= beat_cnt + BW'(1);
          if (rd_valid && beat_last) begin
            if (vsync_rise) state <= FLUSH;
            else begin
              rd_addr   <= rd_addr + ADDR_STEP;
              words_req <= words_req + WORDS_STEP;
              state     <= CHECK;
            end
          end else if (vsync_rise) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_valid) beat_cnt <= beat_cnt + BW'(1);
          if (rd_valid && beat_last) state <= FLUSH;
        end
        DONE: if (vsync_rise) state <= FLUSH;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rd_fifo_ctrl.sv
// Bench for vga_rd_fifo_ctrl with a small frame geometry and an SDRAM read model.
module tb_vga_rd_fifo_ctrl;

  localparam int FW = 64;
  localparam int BL = 8;
  localparam int FD = 32;
  localparam int AW = 22;
  localparam logic [AW-1:0] BASE = 22'h100;
  localparam logic [2:0] S_IDLE = 3'd0, S_CHECK = 3'd2, S_REQ = 3'd3, S_DONE = 3'd6;

  logic          sclk, s_rst_n, vga_vsync, vga_en;
  logic [15:0]   img_data, rd_data;
  logic          rd_req, rd_ack, rd_valid, underflow, overflow;
  logic [AW-1:0] rd_addr;
  logic [2:0]    dbg_state;

  logic          m_valid, tb_valid, stall;
  logic [15:0]   m_data, tb_data;
  logic [AW-1:0] m_addr;
  int            m_phase, m_cnt;
  logic [AW-1:0] req_log[$];
  logic [15:0]   exp_q[$];
  int            n_vec, n_err;

  assign rd_valid = m_valid | tb_valid;
  assign rd_data  = m_valid ? m_data : tb_data;

  vga_rd_fifo_ctrl #(
    .FRAME_WORDS(FW), .BURST_LEN(BL), .FIFO_DEPTH(FD),
    .BASE_ADDR(int'(BASE)), .ADDR_W(AW)
  ) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .vga_vsync(vga_vsync), .vga_en(vga_en),
    .img_data(img_data), .rd_req(rd_req), .rd_ack(rd_ack), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .underflow(underflow),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // SDRAM read model: ack after 4 cycles of rd_req, then BL words back to back.
  initial begin
    rd_ack = 1'b0; m_valid = 1'b0; m_data = 16'h0; m_addr = '0;
    m_phase = 0; m_cnt = 0;
    forever begin
      @(negedge sclk);
      rd_ack  = 1'b0;
      m_valid = 1'b0;
      if (!s_rst_n) begin
        m_phase = 0;
        m_cnt   = 0;
      end else if (m_phase == 0) begin
        if (rd_req && !stall) begin
          m_cnt++;
          if (m_cnt == 4) begin
            rd_ack = 1'b1;
            m_addr = rd_addr;
            req_log.push_back(rd_addr);
            m_phase = 1;
            m_cnt = 0;
          end
        end else m_cnt = 0;
      end else begin
        m_valid = 1'b1;
        m_data  = m_addr[15:0] + m_cnt[15:0];
        m_cnt++;
        if (m_cnt == BL) begin
          m_phase = 0;
          m_cnt = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse_vsync();
    @(negedge sclk); vga_vsync = 1'b1;
    repeat (3) @(negedge sclk);
    vga_vsync = 1'b0;
  endtask

  task automatic pop_n(input int n, input int on_c, input int off_c);
    int done_n = 0;
    while (done_n < n) begin
      for (int k = 0; k < on_c && done_n < n; k++) begin
        @(negedge sclk); vga_en = 1'b1;
        chk("pixel", 32'(img_data), 32'(exp_q.pop_front()));
        done_n++;
      end
      for (int k = 0; k < off_c; k++) begin
        @(negedge sclk); vga_en = 1'b0;
      end
    end
    @(negedge sclk); vga_en = 1'b0;
  endtask

  task automatic wait_req(input int n, input int limit);
    int i = 0;
    while (req_log.size() < n && i < limit) begin
      @(negedge sclk); i++;
    end
    chk("req_timeout", 32'(req_log.size() >= n), 32'd1);
  endtask

  task automatic wait_beat(input int beat, input int limit);
    int i = 0;
    while (!(m_phase == 1 && m_cnt == beat) && i < limit) begin
      @(posedge sclk); i++;
    end
    chk("beat_timeout", 32'(m_phase == 1 && m_cnt == beat), 32'd1);
  endtask

  typedef struct {
    logic        en;
    logic        valid;
    logic [15:0] data;
    logic [15:0] exp_img;
    logic        exp_uf;
    logic        exp_of;
  } vec_t;
  vec_t vt[9];

  initial begin
    vt[0] = '{1'b0, 1'b1, 16'hA001, 16'hA001, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 16'hA002, 16'hA001, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b1, 16'hA003, 16'hA002, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 16'h0000, 16'hA003, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b1, 16'hB00F, 16'hB00F, 1'b1, 1'b0};
    vt[7] = '{1'b1, 1'b1, 16'hC0DE, 16'hC0DE, 1'b1, 1'b0};
    vt[8] = '{1'b0, 1'b0, 16'h0000, 16'hC0DE, 1'b1, 1'b0};

    n_vec = 0; n_err = 0;
    s_rst_n = 1'b0; vga_vsync = 1'b0; vga_en = 1'b0;
    tb_valid = 1'b0; tb_data = 16'h0; stall = 1'b0;

    // reset state
    repeat (3) @(negedge sclk);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_img", 32'(img_data), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);
    chk("rst_of", 32'(overflow), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'(BASE));
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    s_rst_n = 1'b1;
    repeat (10) @(negedge sclk);
    chk("no_req_pre_vsync", 32'(rd_req), 32'd0);

    // FIFO vectors while idle
    for (int i = 0; i < 9; i++) begin
      @(negedge sclk);
      vga_en = vt[i].en; tb_valid = vt[i].valid; tb_data = vt[i].data;
      @(posedge sclk); #1;
      chk("vec_img", 32'(img_data), 32'(vt[i].exp_img));
      chk("vec_uf", 32'(underflow), 32'(vt[i].exp_uf));
      chk("vec_of", 32'(overflow), 32'(vt[i].exp_of));
    end
    @(negedge sclk); vga_en = 1'b0; tb_valid = 1'b0;

    // fill to full, then one extra word must be dropped
    for (int i = 0; i < 31; i++) begin
      tb_valid = 1'b1; tb_data = 16'h5000 + 16'(i);
      @(negedge sclk);
    end
    tb_data = 16'hDEAD;
    @(negedge sclk); tb_valid = 1'b0;
    chk("of_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 32; i++) begin
      @(negedge sclk); vga_en = 1'b1;
      chk("full_pop", 32'(img_data), (i == 0) ? 32'h0000C0DE : 32'h5000 + 32'(i - 1));
    end
    @(negedge sclk); vga_en = 1'b0;
    chk("drained_img", 32'(img_data), 32'd0);
    chk("of_sticky", 32'(overflow), 32'd1);

    // vsync clears flags and starts fetching; no consumer yet
    req_log.delete();
    for (int i = 0; i < FW; i++) exp_q.push_back(BASE[15:0] + 16'(i));
    pulse_vsync();
    chk("uf_cleared", 32'(underflow), 32'd0);
    chk("of_cleared", 32'(overflow), 32'd0);
    wait_req(4, 400);
    repeat (60) @(negedge sclk);
    chk("req_count_full", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      chk("burst_addr", 32'(req_log[i]), 32'(BASE) + 32'(i * BL));
    chk("hold_state", 32'(dbg_state), 32'(S_CHECK));
    chk("hold_req", 32'(rd_req), 32'd0);

    // consume the whole frame in address order
    pop_n(FW, 4, 4);
    repeat (100) @(negedge sclk);
    chk("frame_bursts", 32'(req_log.size()), 32'(FW / BL));
    if (req_log.size() > 0)
      chk("last_addr", 32'(req_log[req_log.size() - 1]), 32'(BASE) + 32'(FW - BL));
    chk("done_state", 32'(dbg_state), 32'(S_DONE));
    chk("frame_uf", 32'(underflow), 32'd0);
    chk("frame_of", 32'(overflow), 32'd0);
    chk("done_img", 32'(img_data), 32'd0);

    // SDRAM stall: empty pops, sticky underflow, vsync during REQ
    stall = 1'b1;
    req_log.delete();
    pulse_vsync();
    repeat (20) @(negedge sclk);
    chk("stall_req", 32'(rd_req), 32'd1);
    chk("stall_addr", 32'(rd_addr), 32'(BASE));
    chk("stall_state", 32'(dbg_state), 32'(S_REQ));
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk); vga_en = 1'b1;
      chk("empty_img", 32'(img_data), 32'd0);
    end
    @(negedge sclk); vga_en = 1'b0;
    chk("uf_set", 32'(underflow), 32'd1);
    repeat (10) @(negedge sclk);
    chk("uf_sticky", 32'(underflow), 32'd1);
    pulse_vsync();
    chk("uf_vsync_clr", 32'(underflow), 32'd0);
    stall = 1'b0;
    wait_req(2, 200);
    if (req_log.size() >= 2) chk("after_owed_addr", 32'(req_log[1]), 32'(BASE));
    for (int i = 0; i < 50 && img_data == 16'h0; i++) @(negedge sclk);
    chk("restart_head", 32'(img_data), 32'(BASE[15:0]));

    // vsync mid-burst: rest of burst discarded, restart at BASE
    repeat (150) @(negedge sclk);
    for (int i = 0; i < BL; i++) exp_q.push_back(BASE[15:0] + 16'(i));
    pop_n(BL, BL, 0);
    wait_beat(3, 100);
    req_log.delete();
    pulse_vsync();
    wait_req(1, 200);
    if (req_log.size() >= 1) chk("drain_next_addr", 32'(req_log[0]), 32'(BASE));
    repeat (30) @(negedge sclk);
    for (int i = 0; i < BL; i++) exp_q.push_back(BASE[15:0] + 16'(i));
    pop_n(BL, BL, 0);
    chk("drain_uf", 32'(underflow), 32'd0);

    // asynchronous reset mid-burst
    wait_beat(4, 300);
    #2 s_rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(rd_req), 32'd0);
    chk("arst_img", 32'(img_data), 32'd0);
    chk("arst_addr", 32'(rd_addr), 32'(BASE));
    chk("arst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("arst_flags", {30'd0, underflow, overflow}, 32'd0);
    @(negedge sclk); s_rst_n = 1'b1;
    repeat (10) @(negedge sclk);
    chk("post_rst_req", 32'(rd_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
